// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if
//   Issue/result bundle between the EX stage and the MDU sequencer.
//   slave  : sequencer side (receives start/mdu_op/srcA/srcB, drives busy/done/hi/lo)
//   master : pipeline side (drives the issue fields, observes status and HI/LO)
//   Optional macro MDU_DIV0_TRAP_EN adds the div0 pulse.
interface mdu_sequencer_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIV0_TRAP_EN
    logic        div0;
`endif

    modport slave (
        input  start, mdu_op, srcA, srcB,
`ifdef MDU_DIV0_TRAP_EN
        output div0,
`endif
        output busy, done, hi, lo
    );

    modport master (
        output start, mdu_op, srcA, srcB,
`ifdef MDU_DIV0_TRAP_EN
        input  div0,
`endif
        input  busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multiply/divide sequencer beside the EX-stage ALU. Accepts one MDU op per
//   start pulse, holds busy for a fixed per-op latency, and owns HI/LO.
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous active-high reset, clears all state (aborts an op in flight)
//     bus    : mdu_sequencer_if.slave (start, mdu_op, srcA, srcB -> busy, done, hi, lo[, div0])
//   Parameters: MULT_CYCLES, DIV_CYCLES (busy length, >= 1).
//   Optional macro MDU_DIV0_TRAP_EN: divide-by-zero is refused and pulses div0
//   instead of running with the default {hi=srcA, lo=all-ones} result.
//
//   state | meaning
//   IDLE  | waiting for start; mthi/mtlo write directly here
//   BUSY  | op in flight, cnt counts down to the commit edge
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic           clk,
    input logic           reset,
    mdu_sequencer_if.slave bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic [31:0]      hi_q, lo_q;
    logic             busy_q, done_q;
`ifdef MDU_DIV0_TRAP_EN
    logic             div0_q;
`endif

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, safe_abs_b, safe_b;
    logic [31:0]        sq_mag, sr_mag;
    logic [31:0]        res_hi_d, res_lo_d;

    // Signed divide works on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 rather than hitting a native signed-overflow case.
    always_comb begin
        prod_s     = 64'($signed(bus.srcA)) * 64'($signed(bus.srcB));
        prod_u     = {32'd0, bus.srcA} * {32'd0, bus.srcB};
        abs_a      = bus.srcA[31] ? (~bus.srcA + 32'd1) : bus.srcA;
        abs_b      = bus.srcB[31] ? (~bus.srcB + 32'd1) : bus.srcB;
        safe_abs_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        safe_b     = (bus.srcB == 32'd0) ? 32'd1 : bus.srcB;
        sq_mag     = abs_a / safe_abs_b;
        sr_mag     = abs_a % safe_abs_b;
        res_hi_d   = 32'd0;
        res_lo_d   = 32'd0;
        case (bus.mdu_op)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                if (bus.srcB == 32'd0) begin
                    res_hi_d = bus.srcA;
                    res_lo_d = 32'hFFFF_FFFF;
                end else begin
                    res_lo_d = (bus.srcA[31] ^ bus.srcB[31]) ? (~sq_mag + 32'd1) : sq_mag;
                    res_hi_d = bus.srcA[31] ? (~sr_mag + 32'd1) : sr_mag;
                end
            end
            OP_DIVU: begin
                if (bus.srcB == 32'd0) begin
                    res_hi_d = bus.srcA;
                    res_lo_d = 32'hFFFF_FFFF;
                end else begin
                    res_lo_d = bus.srcA / safe_b;
                    res_hi_d = bus.srcA % safe_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MDU_DIV0_TRAP_EN
            div0_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIV0_TRAP_EN
            div0_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.mdu_op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= res_hi_d;
                                pend_lo_q <= res_lo_d;
                                cnt_q     <= MULT_CNT;
                                busy_q    <= 1'b1;
                                state_q   <= BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV0_TRAP_EN
                                if (bus.srcB == 32'd0) begin
                                    div0_q <= 1'b1;
                                end else begin
                                    pend_hi_q <= res_hi_d;
                                    pend_lo_q <= res_lo_d;
                                    cnt_q     <= DIV_CNT;
                                    busy_q    <= 1'b1;
                                    state_q   <= BUSY;
                                end
`else
                                pend_hi_q <= res_hi_d;
                                pend_lo_q <= res_lo_d;
                                cnt_q     <= DIV_CNT;
                                busy_q    <= 1'b1;
                                state_q   <= BUSY;
`endif
                            end
                            OP_MTHI: hi_q <= bus.srcA;
                            OP_MTLO: lo_q <= bus.srcA;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // start is ignored here; HI/LO keep their old values until commit.
                    if (cnt_q == CNT_ONE) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
`ifdef MDU_DIV0_TRAP_EN
    assign bus.div0 = div0_q;
`endif
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
//   Scoreboard bench for mdu_sequencer: directed cases followed by random ops.
//   Honours MDU_DIV0_TRAP_EN when defined for the build.
module tb_mdu_sequencer;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    mdu_sequencer_if bus_if ();

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi, model_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            3'd1: begin q = sa * sb; res = q; end
            3'd2: begin p = ua * ub; res = p; end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    p = ua / ub;
                    res[31:0] = p[31:0];
                    p = ua % ub;
                    res[63:32] = p[31:0];
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic bit trap_build();
`ifdef MDU_DIV0_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1 expected no commit pending");
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("commit_hi", bus_if.hi, e[63:32]);
                check("commit_lo", bus_if.lo, e[31:0]);
            end
        end
    end

    // Issue one op; optionally try a second start while the first is in flight.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, input logic [2:0] op2);
        bit          accepted;
        int          lat, n;
        logic [63:0] e;
        accepted = (op >= 3'd1 && op <= 3'd4) &&
                   !(trap_build() && (op == 3'd3 || op == 3'd4) && b == 32'd0);
        lat = (op == 3'd1 || op == 3'd2) ? MULT_N : DIV_N;
        @(negedge clk);
        bus_if.start  = 1'b1;
        bus_if.mdu_op = op;
        bus_if.srcA   = a;
        bus_if.srcB   = b;
        @(negedge clk);
        bus_if.start  = intrude && accepted;
        bus_if.mdu_op = op2;
        bus_if.srcA   = $urandom;
        bus_if.srcB   = $urandom;
        if (accepted) begin
            e = ref_result(op, a, b);
            sb_q.push_back(e);
            check("busy_after_accept", {31'd0, bus_if.busy}, 32'd1);
            check("hi_held", bus_if.hi, model_hi);
            check("lo_held", bus_if.lo, model_lo);
            n = 0;
            while (bus_if.busy === 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
                bus_if.start = 1'b0;
            end
            bus_if.start = 1'b0;
            check("busy_cycles", n, lat);
            check("done_pulse", {31'd0, bus_if.done}, 32'd1);
            model_hi = e[63:32];
            model_lo = e[31:0];
            @(negedge clk);
            check("done_single", {31'd0, bus_if.done}, 32'd0);
            check("hi_after", bus_if.hi, model_hi);
            check("lo_after", bus_if.lo, model_lo);
        end else begin
            if (op == 3'd5) model_hi = a;
            if (op == 3'd6) model_lo = a;
            check("busy_idle", {31'd0, bus_if.busy}, 32'd0);
            check("done_idle", {31'd0, bus_if.done}, 32'd0);
            check("hi_direct", bus_if.hi, model_hi);
            check("lo_direct", bus_if.lo, model_lo);
`ifdef MDU_DIV0_TRAP_EN
            check("div0_pulse", {31'd0, bus_if.div0},
                  {31'd0, ((op == 3'd3 || op == 3'd4) && b == 32'd0)});
            @(negedge clk);
            check("div0_clear", {31'd0, bus_if.div0}, 32'd0);
`endif
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start  = 1'b0;
        bus_if.mdu_op = 3'd0;
        bus_if.srcA   = 32'd0;
        bus_if.srcB   = 32'd0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_hi", bus_if.hi, 32'd0);
        check("rst_lo", bus_if.lo, 32'd0);

        // Give HI/LO nonzero values, then abort a mult with reset.
        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 3'd0);
        run_op(3'd6, 32'hCAFE_F00D, 32'd0, 1'b0, 3'd0);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.mdu_op = 3'd1;
        bus_if.srcA = 32'd7; bus_if.srcB = 32'd9;
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_done", {31'd0, bus_if.done}, 32'd0);
        check("abort_hi", bus_if.hi, 32'd0);
        check("abort_lo", bus_if.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_commit_hi", bus_if.hi, 32'd0);
        check("abort_no_commit_lo", bus_if.lo, 32'd0);

        // Directed cases.
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 3'd0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3'd0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 3'd0);
        run_op(3'd4, 32'd7, 32'd2, 1'b0, 3'd0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 3'd0);
        run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0, 3'd0);
        run_op(3'd1, 32'd1000, 32'd3000, 1'b1, 3'd6);
        run_op(3'd3, 32'd100, 32'd7, 1'b1, 3'd1);
        run_op(3'd4, 32'd5, 32'd0, 1'b0, 3'd0);
        run_op(3'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 3'd0);
        run_op(3'd0, 32'h1111_1111, 32'd1, 1'b0, 3'd0);
        run_op(3'd7, 32'h2222_2222, 32'd1, 1'b0, 3'd0);

        // Random ops with a bias toward small and zero divisors.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op, op2;
            logic [31:0] a, b;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            op2 = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = 32'($urandom_range(1, 9));
            else if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            else               b = $urandom;
            run_op(op, a, b, ($urandom_range(0, 3) == 0), op2);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
